// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU datapath blocks. DATA_W is the
//               operand/result width, SHAMT_W the shift-amount width, and
//               SRA_STAGES the number of levels in the logarithmic shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int SRA_STAGES = 5;

  // Shift distance handled by shifter level 'idx' when levels are ordered
  // largest first (idx 0 -> 16, idx 4 -> 1).
  function automatic int stage_shift(input int idx);
    return 1 << (SRA_STAGES - 1 - idx);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/sra_stage.sv
`default_nettype none
// ============================================================================
// Module      : sra_stage
// Description : One level of the arithmetic barrel shifter. When en is high
//               the word is shifted right by SHIFT and the vacated high bits
//               are filled with sign; otherwise the word passes through.
// Ports       : in   [DATA_W-1:0]  data from previous level
//               en                 apply this level's shift
//               sign               fill bit (original operand MSB)
//               out  [DATA_W-1:0]  data to next level
// Revision    : 1.0 - initial release
// ============================================================================
module sra_stage
  import alu_pkg::*;
#(
  parameter int SHIFT   = 1,
  parameter int STAGE_W = DATA_W
) (
  input  logic [STAGE_W-1:0] in,
  input  logic               en,
  input  logic               sign,
  output logic [STAGE_W-1:0] out
);

  logic [STAGE_W-1:0] shifted;

  assign shifted = {{SHIFT{sign}}, in[STAGE_W-1:SHIFT]};
  assign out     = en ? shifted : in;

endmodule : sra_stage
`default_nettype wire

// File: rtl/sra_unit.sv
`default_nettype none
// ============================================================================
// Module      : sra_unit
// Description : 32-bit arithmetic right shifter. A five-level logarithmic
//               barrel shifter (levels 16, 8, 4, 2, 1) produces a
//               zero-latency result for the ALU result mux, and a registered
//               copy is provided for pipelined consumers.
// Ports       : clock      rising-edge clock
//               reset      synchronous active-high, clears out_q/out_valid
//               in         signed operand
//               sh_amt     shift amount 0..31
//               in_valid   qualifies in/sh_amt for the registered path
//               out        combinational $signed(in) >>> sh_amt
//               out_q      registered result
//               out_valid  registered in_valid
// Revision    : 1.0 - initial release
// ============================================================================
module sra_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] sh_amt,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out,
  output logic [DATA_W-1:0]  out_q,
  output logic               out_valid
);

  import alu_pkg::SRA_STAGES;
  import alu_pkg::stage_shift;

  // stage_data[0] is the raw operand, stage_data[SRA_STAGES] the result.
  logic [DATA_W-1:0] stage_data [0:SRA_STAGES];
  logic              sign_bit;

  // Every level fills with the original MSB rather than the MSB of its own
  // input; both are equal for an arithmetic shift, but this keeps the sign
  // net off the level-to-level critical path.
  assign sign_bit      = in[DATA_W-1];
  assign stage_data[0] = in;

  // Fixed largest-first ordering keeps timing reports stable between runs.
  for (genvar g = 0; g < SRA_STAGES; g++) begin : g_stage
    localparam int SHIFT = stage_shift(g);
    localparam int SBIT  = SRA_STAGES - 1 - g;

    sra_stage #(
      .SHIFT   (SHIFT),
      .STAGE_W (DATA_W)
    ) u_stage (
      .in   (stage_data[g]),
      .en   (sh_amt[SBIT]),
      .sign (sign_bit),
      .out  (stage_data[g+1])
    );
  end : g_stage

  assign out = stage_data[SRA_STAGES];

  // Reset takes priority over a same-cycle in_valid, dropping that operation.
  // out_q keeps its last result when no new operation is presented.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

endmodule : sra_unit
`default_nettype wire

// File: tb/tb_sra_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sra_unit
// Description : Self-checking bench for sra_unit. Directed vectors followed by
//               a randomized sweep compared against a bit-rule reference model
//               and a behavioural model of the registered path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sra_unit;

  logic        clock;
  logic        reset;
  logic [31:0] in;
  logic [4:0]  sh_amt;
  logic        in_valid;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q;
  logic        exp_v;

  sra_unit #(
    .DATA_W  (32),
    .SHAMT_W (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .sh_amt    (sh_amt),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: out[i] = in[i+s] while in range, otherwise the sign bit.
  function automatic logic [31:0] ref_sra(input logic [31:0] d, input logic [4:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      if (i + int'(s) <= 31) r[i] = d[i + int'(s)];
      else                   r[i] = d[31];
    end
    return r;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Called just after a rising edge: drive inputs, check the combinational
  // result mid-cycle, advance one edge and check the registered path.
  task automatic cycle(input logic [31:0] d, input logic [4:0] s,
                       input logic v, input logic r);
    in       = d;
    sh_amt   = s;
    in_valid = v;
    reset    = r;
    #4;
    check32("comb_out", out, ref_sra(d, s));
    if (r) begin
      exp_q = 32'h0;
      exp_v = 1'b0;
    end else begin
      if (v) exp_q = ref_sra(d, s);
      exp_v = v;
    end
    @(posedge clock);
    #1;
    check32("out_q", out_q, exp_q);
    check1("out_valid", out_valid, exp_v);
  endtask

  initial begin
    logic [31:0] rd;
    logic [4:0]  rs;
    logic        rv;
    logic        rr;

    reset    = 1'b1;
    in_valid = 1'b0;
    in       = 32'h0;
    sh_amt   = 5'd0;
    exp_q    = 32'h0;
    exp_v    = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check32("reset_out_q", out_q, 32'h0);
    check1("reset_out_valid", out_valid, 1'b0);

    // Directed vectors with literal expected values.
    cycle(32'h80000000, 5'd4, 1'b0, 1'b0);
    check32("sign_fill_4", out, 32'hF8000000);
    cycle(32'h87654321, 5'd16, 1'b0, 1'b0);
    check32("sign_fill_16", out, 32'hFFFF8765);
    cycle(32'h12345678, 5'd8, 1'b0, 1'b0);
    check32("pos_8", out, 32'h00123456);
    cycle(32'h7FFFFFFF, 5'd31, 1'b0, 1'b0);
    check32("pos_31", out, 32'h00000000);
    cycle(32'hFFFFFFFF, 5'd31, 1'b0, 1'b0);
    check32("neg_31", out, 32'hFFFFFFFF);
    cycle(32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
    check32("shift_0", out, 32'hDEADBEEF);

    // Registered path: capture, then hold with valid dropped.
    cycle(32'h80000000, 5'd1, 1'b1, 1'b0);
    check32("reg_capture_q", out_q, 32'hC0000000);
    check1("reg_capture_v", out_valid, 1'b1);
    cycle(32'h00001234, 5'd3, 1'b0, 1'b0);
    check32("reg_hold_q", out_q, 32'hC0000000);
    check1("reg_hold_v", out_valid, 1'b0);

    // Back-to-back valids, then reset colliding with a valid operation.
    cycle(32'hF0F0F0F0, 5'd5, 1'b1, 1'b0);
    cycle(32'h0F0F0F0F, 5'd2, 1'b1, 1'b0);
    check32("b2b_q", out_q, 32'h03C3C3C3);
    cycle(32'hA5A5A5A5, 5'd7, 1'b1, 1'b1);
    check32("reset_wins_q", out_q, 32'h0);
    check1("reset_wins_v", out_valid, 1'b0);
    check32("out_during_reset", out, 32'hFF4B4B4B);

    // Random sweep.
    for (int n = 0; n < 1200; n++) begin
      rd = $urandom;
      case ($urandom_range(0, 7))
        0:       rs = 5'd0;
        1:       rs = 5'd31;
        default: rs = 5'($urandom_range(0, 31));
      endcase
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 49) == 0);
      cycle(rd, rs, rv, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sra_unit
`default_nettype wire

// File: doc/sra_unit.md
# sra_unit

32-bit arithmetic right shifter for the ALU datapath. Shifts a signed 32-bit operand right by a 5-bit amount and fills vacated high bits with copies of bit 31.
- The combinational result `out` feeds the ALU result mux with zero latency.
- A registered copy (`out_q`, `out_valid`) serves pipelined consumers.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width; only 32 is supported.
- `SHAMT_W`, 5: shift-amount width; equals log2(`DATA_W`).

Ports:
- `clock`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high; clears the registered outputs only.
- `in`  in  32  operand, treated as two's-complement signed.
- `sh_amt`  in  5  shift amount, unsigned, 0..31.
- `in_valid`  in  1  qualifies `in`/`sh_amt` for the registered path.
- `out`  out  32  combinational result, equal to `$signed(in) >>> sh_amt`.
- `out_q`  out  32  registered result.
- `out_valid`  out  1  registered `in_valid`.

## Operation
- `out[i]` = `in[i+sh_amt]` for i + `sh_amt` ≤ 31; otherwise `out[i]` = `in[31]`.
- Implemented as a 5-level logarithmic barrel shifter.
  - Level k (k = 4..0) shifts by 2^k when `sh_amt[k]` = 1, otherwise passes through.
  - Each level fills its vacated high bits with the original `in[31]`.
- `sh_amt` = 0: `out` = `in` exactly.
- `sh_amt` = 31: `out` = all-ones if `in[31]` = 1, otherwise all-zeros.
- No X-propagation tolerance is needed beyond standard logic. An X on any `sh_amt` bit may yield X on `out`.
- No overflow or flag outputs. Shift amounts ≥ 32 are not representable.

## Timing
- `out`:
  - Purely combinational from `in` and `sh_amt`; 0-cycle latency.
  - Settles within one clock period.
  - Not affected by `reset`.
- Registered path, at each rising edge of `clock`:
  - `reset` = 1: `out_q` ← 0, `out_valid` ← 0.
  - Else `in_valid` = 1: `out_q` ← current `out`, `out_valid` ← 1.
  - Else: `out_q` holds its value, `out_valid` ← 0.
- Latency is 1 cycle from `in_valid` to `out_valid`.
- Throughput is one operation per cycle. No backpressure and no handshake beyond `in_valid`.
- Reset values: `out_q` = 32'h0, `out_valid` = 0. `out` follows its inputs at all times, including during reset.
- Reset asserted in the same cycle as `in_valid`: reset wins, and the operation is dropped.
- Back-to-back valid inputs each produce a result exactly one cycle later. There is no bubble.

## Structure
- Shared package `alu_pkg`:
  - constants `DATA_W` = 32 and `SHAMT_W` = 5;
  - localparam `SRA_STAGES` = 5.
- One sub-module, `sra_stage`:
  - parameter `SHIFT` (power of two);
  - ports: data in/out 32, `en` 1, `sign` 1.
  - `out` = `en` ? {{SHIFT{`sign`}}, `in`[31:SHIFT]} : `in`.
- `sra_unit` instantiates five `sra_stage` instances in order 16, 8, 4, 2, 1, plus the output register.
- Ordering does not affect the result, but this order is fixed for timing-report consistency.

## Test plan
- Sign fill:
  - `in`=32'h80000000, `sh_amt`=4 -> `out`=32'hF8000000.
  - `in`=32'h87654321, `sh_amt`=16 -> `out`=32'hFFFF8765.
- Positive operands:
  - `in`=32'h12345678, `sh_amt`=8 -> `out`=32'h00123456.
  - `in`=32'h7FFFFFFF, `sh_amt`=31 -> `out`=32'h00000000.
- Extremes:
  - `in`=32'hFFFFFFFF, `sh_amt`=31 -> `out`=32'hFFFFFFFF.
  - `in`=32'hDEADBEEF, `sh_amt`=0 -> `out`=32'hDEADBEEF.
- Registered path:
  - Apply `in`=32'h80000000, `sh_amt`=1, `in_valid`=1 for one cycle.
  - Next edge -> `out_q`=32'hC0000000, `out_valid`=1.
  - The following cycle, with `in_valid`=0 -> `out_valid`=0 and `out_q` held.
- Reset:
  - Assert `reset` together with `in_valid`=1 -> after the edge, `out_q`=0 and `out_valid`=0.
  - `out` still equals the shifted `in` throughout.
- Random sweep:
  - At least 1000 random (`in`, `sh_amt`) pairs, one per 10 ns.
  - Check `out` === `$signed(in) >>> sh_amt` 5 ns after each change.
  - Check `out_q` against the value captured one edge earlier.
